// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
// Read-side drain engine for the async FIFO (read clock domain only).
// Requests words from the FIFO with a credit rule so they can never overrun a
// small prefetch buffer. It then re-presents the buffered words as a
// valid/ready stream, supports a one-cycle flush, flags FIFO read-protocol
// violations and counts stream transfers.
//
// Ports
//   rd_clk      in   1           FIFO read clock
//   rst_n       in   1           asynchronous active-low reset
//   fifo_empty  in   1           FIFO empty flag
//   fifo_rdata  in   data_width  FIFO read data (valid with fifo_valid)
//   fifo_valid  in   1           FIFO read data valid, one cycle after rd_en
//   rd_en       out  1           FIFO read request
//   m_data      out  data_width  stream data (head of prefetch buffer)
//   m_valid     out  1           stream valid
//   m_ready     in   1           stream ready
//   flush       in   1           discard buffered and in-flight words
//   proto_err   out  1           sticky FIFO read-protocol violation flag
//   word_cnt    out  cnt_width   stream transfers since reset (wraps)
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
    parameter int data_width = 8,
    parameter int buf_depth  = 3,   // legal 2..4
    parameter int cnt_width  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [data_width-1:0] fifo_rdata,
    input  logic                  fifo_valid,
    output logic                  rd_en,
    output logic [data_width-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    input  logic                  flush,
    output logic                  proto_err,
    output logic [cnt_width-1:0]  word_cnt
);

    localparam logic [2:0] DEPTH    = 3'(buf_depth);
    localparam logic [1:0] PTR_LAST = 2'(buf_depth - 1);

    // Circular-buffer pointer increment that wraps at the buffer depth.
    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
    endfunction

    logic [data_width-1:0] r_mem [0:buf_depth-1];
    logic [1:0]            r_head;
    logic [2:0]            r_occ;
    logic                  r_inflight;
    logic                  r_drop;
    logic                  r_proto_err;
    logic [cnt_width-1:0]  r_word_cnt;

    logic       w_rd_en;
    logic       w_pop;
    logic       w_arrive;
    logic       w_full;
    logic       w_write;
    logic [2:0] w_tail_sum;
    logic [2:0] w_tail_wrap;
    logic [1:0] w_tail;
    logic [2:0] w_occ_nxt;
    logic       w_drop_nxt;
    logic       w_err_set;

    // Credit rule: a word is requested only if it is guaranteed a buffer slot.
    // rst_n gates the request so the FIFO is never read while in reset.
    assign w_rd_en = rst_n && !fifo_empty && !flush &&
                     ((r_occ + {2'b00, r_inflight}) < DEPTH);

    assign w_pop    = (r_occ != 3'd0) && m_ready;
    assign w_arrive = fifo_valid && !r_drop;
    assign w_full   = (r_occ == DEPTH);
    // When full, a same-cycle pop frees the head slot, which is exactly the tail.
    assign w_write  = w_arrive && !flush && (!w_full || w_pop);

    assign w_tail_sum  = {1'b0, r_head} + r_occ;
    assign w_tail_wrap = (w_tail_sum >= DEPTH) ? (w_tail_sum - DEPTH) : w_tail_sum;
    assign w_tail      = w_tail_wrap[1:0];

    // Next-state for occupancy, drop marker and protocol-error detection.
    always_comb begin
        w_occ_nxt  = r_occ;
        w_drop_nxt = r_drop;
        w_err_set  = 1'b0;

        if (flush) begin
            w_occ_nxt = 3'd0;
        end else begin
            case ({w_write, w_pop})
                2'b10:   w_occ_nxt = r_occ + 3'd1;
                2'b01:   w_occ_nxt = r_occ - 3'd1;
                default: w_occ_nxt = r_occ;
            endcase
        end

        // A word arriving in the flush cycle itself is already discarded by
        // the flush; only a requested word that has not yet shown up needs
        // to be dropped later.
        if (flush) begin
            w_drop_nxt = r_inflight && !fifo_valid;
        end else if (fifo_valid && r_drop) begin
            w_drop_nxt = 1'b0;
        end else begin
            w_drop_nxt = r_drop;
        end

        if ((fifo_valid && !r_inflight && !r_drop) ||
            (r_inflight && !fifo_valid) ||
            (w_arrive && w_full && !w_pop)) begin
            w_err_set = 1'b1;
        end else begin
            w_err_set = 1'b0;
        end
    end

    // Control registers: pointers, occupancy, in-flight/drop, error, counter.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head      <= 2'd0;
            r_occ       <= 3'd0;
            r_inflight  <= 1'b0;
            r_drop      <= 1'b0;
            r_proto_err <= 1'b0;
            r_word_cnt  <= '0;
        end else begin
            r_occ       <= w_occ_nxt;
            r_inflight  <= w_rd_en;
            r_drop      <= w_drop_nxt;
            r_proto_err <= r_proto_err || w_err_set;
            if (w_pop) begin
                r_head     <= next_ptr(r_head);
                r_word_cnt <= r_word_cnt + cnt_width'(1);
            end else begin
                r_head     <= r_head;
                r_word_cnt <= r_word_cnt;
            end
        end
    end

    // Prefetch storage: arriving words are written at the tail slot.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < buf_depth; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_write) begin
                r_mem[w_tail] <= fifo_rdata;
            end else begin
                r_mem[w_tail] <= r_mem[w_tail];
            end
        end
    end

    assign rd_en     = w_rd_en;
    assign m_valid   = (r_occ != 3'd0);
    assign m_data    = r_mem[r_head];
    assign proto_err = r_proto_err;
    assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

    logic        rd_clk = 1'b0;
    logic        rst_n;
    logic        fifo_empty;
    logic [7:0]  fifo_rdata;
    logic        fifo_valid;
    logic        m_ready;
    logic        flush;

    logic        rd_en,     rd_en_4;
    logic [7:0]  m_data,    m_data_4;
    logic        m_valid,   m_valid_4;
    logic        proto_err, proto_err_4;
    logic [15:0] word_cnt;
    logic [3:0]  word_cnt_4;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] q [$];
    logic [7:0] rx [$];
    logic       inj;
    int         cyc;
    int         first_xfer;
    int         last_xfer;
    int         n_rden;
    int         n_bad;
    logic       obs_rd_en;
    logic       obs_m_valid;
    logic [7:0] obs_m_data;

    always #5 rd_clk = ~rd_clk;

    fifo_rd_stream #(.data_width(8), .buf_depth(3), .cnt_width(16)) dut (
        .rd_clk(rd_clk), .rst_n(rst_n), .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata), .fifo_valid(fifo_valid), .rd_en(rd_en),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .flush(flush),
        .proto_err(proto_err), .word_cnt(word_cnt)
    );

    fifo_rd_stream #(.data_width(8), .buf_depth(3), .cnt_width(4)) dut4 (
        .rd_clk(rd_clk), .rst_n(rst_n), .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata), .fifo_valid(fifo_valid), .rd_en(rd_en_4),
        .m_data(m_data_4), .m_valid(m_valid_4), .m_ready(m_ready), .flush(flush),
        .proto_err(proto_err_4), .word_cnt(word_cnt_4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample DUT at negedge, then model the FIFO after posedge.
    task automatic tick();
        logic take;
        @(negedge rd_clk);
        take        = rd_en;
        obs_rd_en   = rd_en;
        obs_m_valid = m_valid;
        obs_m_data  = m_data;
        if (rd_en) n_rden++;
        if (m_valid && m_ready) begin
            rx.push_back(m_data);
            if (first_xfer < 0) first_xfer = cyc;
            last_xfer = cyc;
        end
        @(posedge rd_clk);
        #1;
        cyc++;
        if (take && q.size() > 0) begin
            fifo_valid = 1'b1;
            fifo_rdata = q.pop_front();
        end else begin
            fifo_valid = inj;
            fifo_rdata = inj ? 8'hEE : 8'h00;
        end
        fifo_empty = (q.size() == 0);
    endtask

    task automatic load(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) q.push_back(base + 8'(i));
        fifo_empty = (q.size() == 0);
    endtask

    task automatic restart_stats();
        rx.delete();
        cyc = 0; first_xfer = -1; last_xfer = -1; n_rden = 0; n_bad = 0;
    endtask

    initial begin
        rst_n = 1'b0; fifo_empty = 1'b0; fifo_rdata = 8'h00; fifo_valid = 1'b0;
        m_ready = 1'b0; flush = 1'b0; inj = 1'b0;
        restart_stats();

        // T1 reset with a non-empty FIFO
        #12;
        check("t1_rd_en",     {31'd0, rd_en},     32'd0);
        check("t1_m_valid",   {31'd0, m_valid},   32'd0);
        check("t1_word_cnt",  {16'd0, word_cnt},  32'd0);
        check("t1_proto_err", {31'd0, proto_err}, 32'd0);
        check("t1_m_data",    {24'd0, m_data},    32'd0);
        fifo_empty = 1'b1;
        @(posedge rd_clk); #1;
        rst_n = 1'b1;

        // T2 streaming 0x10..0x1F with m_ready=1
        restart_stats();
        m_ready = 1'b1;
        load(8'h10, 16);
        for (int i = 0; i < 24; i++) tick();
        check("t2_count", rx.size(), 32'd16);
        for (int i = 0; i < 16 && i < rx.size(); i++)
            check($sformatf("t2_word%0d", i), {24'd0, rx[i]}, 32'h10 + i);
        check("t2_latency",   first_xfer, 32'd2);
        check("t2_gapfree",   last_xfer - first_xfer, 32'd15);
        check("t2_word_cnt",  {16'd0, word_cnt},  32'd16);
        check("t2_proto_err", {31'd0, proto_err}, 32'd0);

        // T3 backpressure: 10 stalled cycles, 8 words in FIFO
        restart_stats();
        m_ready = 1'b0;
        load(8'h20, 8);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (obs_m_valid && obs_m_data !== 8'h20) n_bad++;
        end
        check("t3_rd_en_pulses", n_rden, 32'd3);
        check("t3_fifo_left",    q.size(), 32'd5);
        check("t3_m_valid",      {31'd0, obs_m_valid}, 32'd1);
        check("t3_head_stable",  n_bad, 32'd0);
        check("t3_head_data",    {24'd0, obs_m_data}, 32'h20);
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        check("t3_count", rx.size(), 32'd8);
        for (int i = 0; i < 8 && i < rx.size(); i++)
            check($sformatf("t3_word%0d", i), {24'd0, rx[i]}, 32'h20 + i);
        check("t3_word_cnt", {16'd0, word_cnt}, 32'd24);

        // T4 flush in the cycle after rd_en
        restart_stats();
        load(8'h30, 3);
        tick();
        check("t4_rd_en_req", {31'd0, obs_rd_en}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_rd_en_flush", {31'd0, obs_rd_en}, 32'd0);
        tick();
        check("t4_m_valid_after", {31'd0, obs_m_valid}, 32'd0);
        for (int i = 0; i < 10; i++) tick();
        check("t4_count", rx.size(), 32'd2);
        if (rx.size() > 0) check("t4_next_word", {24'd0, rx[0]}, 32'h31);
        check("t4_proto_err", {31'd0, proto_err}, 32'd0);
        check("t4_word_cnt",  {16'd0, word_cnt},  32'd26);

        // T5 unsolicited fifo_valid sets the sticky error
        inj = 1'b1;
        tick();
        inj = 1'b0;
        tick();
        tick();
        check("t5_proto_err", {31'd0, proto_err}, 32'd1);
        for (int i = 0; i < 5; i++) tick();
        check("t5_sticky", {31'd0, proto_err}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_cleared", {31'd0, proto_err}, 32'd0);
        fifo_valid = 1'b0;
        @(posedge rd_clk); #1;
        rst_n = 1'b1;

        // T6 counter wrap at cnt_width=4 and async reset mid-burst
        restart_stats();
        load(8'h40, 17);
        for (int i = 0; i < 26; i++) tick();
        check("t6_count",       rx.size(), 32'd17);
        check("t6_word_cnt_4",  {28'd0, word_cnt_4}, 32'd1);
        check("t6_word_cnt_16", {16'd0, word_cnt},   32'd17);
        load(8'h60, 8);
        for (int i = 0; i < 5; i++) tick();
        check("t6_midburst_valid", {31'd0, obs_m_valid}, 32'd1);
        @(negedge rd_clk); #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_m_valid",   {31'd0, m_valid},    32'd0);
        check("t6_rst_m_data",    {24'd0, m_data},     32'd0);
        check("t6_rst_word_cnt",  {16'd0, word_cnt},   32'd0);
        check("t6_rst_word_cnt4", {28'd0, word_cnt_4}, 32'd0);
        check("t6_rst_proto_err", {31'd0, proto_err},  32'd0);
        check("t6_rst_rd_en",     {31'd0, rd_en},      32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
